pos_sequencer: RTL and testbench
================================

POS_SEQUENCER -- requirements
Module: pos_sequencer

Interface
REQ-001 SHALL have parameter LOG2DELAY, default 20, meaning the step period is 2^LOG2DELAY clocks.
REQ-002 SHALL have parameter NPOS, default 23, meaning the number of positions (legal range 2..32).
REQ-003 SHALL have parameter DEB_BITS, default 16, meaning the debounce window is 2^DEB_BITS-1 clocks.
REQ-004 SHALL have port CLK, input, width 1: the single clock; all state is on its rising edge.
REQ-005 SHALL have port RST_N, input, width 1: reset, asynchronous, active-low.
REQ-006 SHALL have port BTN_N, input, width 1: raw, asynchronous, bouncing button; 0 = pressed.
REQ-007 SHALL have port POS, output, width 5: current position index, 0..NPOS-1, consumed by the pin-driver stage.
REQ-008 SHALL have port STEP, output, width 1: one-cycle pulse in the first cycle POS shows a new value.
REQ-009 SHALL have port MODE, output, width 2: 00 = RUN_FWD, 01 = RUN_REV, 10 = PAUSE; 11 is never driven.
REQ-010 SHALL have port BTN_PRESS, output, width 1: one-cycle pulse per debounced press.

Function
REQ-011 SHALL synchronise BTN_N through two flops before any other use.
REQ-012 SHALL keep a debounced level and a DEB_BITS-bit counter with these rules:
- synchronised level equals debounced level: counter clears.
- levels differ: counter increments.
- levels differ and counter equals 2^DEB_BITS-1: debounced level takes the synchronised level and counter clears.
REQ-013 SHALL pulse BTN_PRESS for exactly one cycle on each debounced 1->0 transition; a 0->1 transition produces no event.
REQ-014 SHALL implement an FSM with states RUN_FWD, RUN_REV and PAUSE; each BTN_PRESS advances RUN_FWD -> RUN_REV -> PAUSE -> RUN_FWD, and MODE updates the cycle after BTN_PRESS.
REQ-015 SHALL run a LOG2DELAY-bit prescaler as follows:
- RUN states: increments every cycle; a tick occurs when it wraps from all-ones to 0.
- PAUSE: holds its value.
- any state change: clears to 0.
REQ-016 SHALL, on a tick in RUN_FWD, set POS to 0 if POS = NPOS-1, else POS+1.
REQ-017 SHALL, on a tick in RUN_REV, set POS to NPOS-1 if POS = 0, else POS-1.
REQ-018 SHALL hold POS in PAUSE and never assert STEP there.
REQ-019 SHALL let a state change win over a tick in the same cycle: POS unchanged, no STEP, prescaler cleared.
REQ-020 SHALL register POS, STEP, MODE and BTN_PRESS (no combinational input-to-output path).
REQ-021 SHALL keep POS within 0..NPOS-1 in every cycle; wrap arithmetic is modulo NPOS, never modulo 32.
REQ-022 SHALL resume from the frozen POS when leaving PAUSE, with the first tick 2^LOG2DELAY cycles later.

Reset
REQ-023 SHALL, on RST_N low, immediately force the following, independent of CLK:
- outputs: POS = 0, STEP = 0, BTN_PRESS = 0, MODE = 00.
- internal: synchroniser flops = 1, debounced level = 1, all counters = 0.
REQ-024 SHALL begin prescaling on the first CLK edge after RST_N deasserts; a button held low through reset yields exactly one BTN_PRESS after the debounce window.

Verification (LOG2DELAY=2, DEB_BITS=2, NPOS=23 unless stated)
REQ-025 SHALL cover: release reset, BTN_N=1 -> POS 0,1,2,... every 4 cycles, STEP with each change, 22 -> 0 wrap, MODE=00.
REQ-026 SHALL cover: BTN_N low for 2 cycles then high, repeated 5 times -> no BTN_PRESS, MODE stays 00, stepping undisturbed.
REQ-027 SHALL cover: BTN_N low held 10 cycles -> exactly one BTN_PRESS, MODE=01, POS decrements with 0 -> 22 wrap.
REQ-028 SHALL cover: press twice more -> MODE=10 then 00; in PAUSE POS frozen and STEP=0 for 100 cycles; after the resume, first STEP exactly 4 cycles later, from the frozen POS+1.
REQ-029 SHALL cover: press timed so BTN_PRESS-driven state change coincides with a tick -> no STEP that cycle, next STEP 4 cycles after the state change.
REQ-030 SHALL cover: RST_N pulsed low between clock edges mid-run in RUN_REV -> POS=0, MODE=00 and STEP=0 before the next CLK edge.

Source files
------------

// File: rtl/pos_sequencer.sv
// Position sequencer: debounced push-button cycles between forward run,
// reverse run and pause; a prescaler paces position steps in the run modes.
module pos_sequencer #(
  parameter int unsigned LOG2DELAY = 20,
  parameter int unsigned NPOS      = 23,
  parameter int unsigned DEB_BITS  = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_N,
  output logic [4:0] POS,
  output logic       STEP,
  output logic [1:0] MODE,
  output logic       BTN_PRESS
);

  localparam int unsigned POS_W = 5;

  localparam logic [DEB_BITS-1:0]  DEB_MAX   = '1;
  localparam logic [LOG2DELAY-1:0] PRESC_MAX = '1;
  localparam logic [POS_W-1:0]     LAST_POS  = POS_W'(NPOS - 1);

  typedef enum logic [1:0] {
    RUN_FWD = 2'b00,
    RUN_REV = 2'b01,
    PAUSE   = 2'b10
  } state_t;

  logic                 sync1;
  logic                 sync2;
  logic                 deb;
  logic [DEB_BITS-1:0]  deb_cnt;
  state_t               state;
  logic [LOG2DELAY-1:0] presc;
  logic                 tick;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= BTN_N;
      sync2 <= sync1;
    end
  end

  // Debouncer: the level must disagree for a full window before it is accepted;
  // a press event fires only on the accepted high-to-low transition
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      deb       <= 1'b1;
      deb_cnt   <= '0;
      BTN_PRESS <= 1'b0;
    end else begin
      BTN_PRESS <= 1'b0;
      if (sync2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_MAX) begin
        deb       <= sync2;
        deb_cnt   <= '0;
        BTN_PRESS <= deb & ~sync2;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // A tick is the prescaler wrap in a run mode; a pending mode change suppresses it
  assign tick = (state != PAUSE) && (presc == PRESC_MAX) && !BTN_PRESS;

  // Mode FSM, prescaler and position stepping
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= RUN_FWD;
      presc <= '0;
      POS   <= '0;
      STEP  <= 1'b0;
    end else begin
      STEP <= 1'b0;
      if (BTN_PRESS) begin
        presc <= '0;
        unique case (state)
          RUN_FWD: state <= RUN_REV;
          RUN_REV: state <= PAUSE;
          default: state <= RUN_FWD;
        endcase
      end else if (state != PAUSE) begin
        presc <= presc + 1'b1;
        if (tick) begin
          STEP <= 1'b1;
          if (state == RUN_FWD) begin
            POS <= (POS == LAST_POS) ? '0 : POS + 1'b1;
          end else begin
            POS <= (POS == '0) ? LAST_POS : POS - 1'b1;
          end
        end
      end
    end
  end

  assign MODE = state;

endmodule

// File: tb/tb_pos_sequencer.sv
// Self-checking bench for pos_sequencer with a cycle-level behavioural model.
module tb_pos_sequencer;

  localparam int NPOS    = 23;
  localparam int PER     = 4;   // 2^LOG2DELAY
  localparam int DEB_WIN = 3;   // 2^DEB_BITS-1

  logic       CLK;
  logic       RST_N;
  logic       BTN_N;
  logic [4:0] POS;
  logic       STEP;
  logic [1:0] MODE;
  logic       BTN_PRESS;

  pos_sequencer #(.LOG2DELAY(2), .NPOS(NPOS), .DEB_BITS(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .BTN_N(BTN_N),
    .POS(POS), .STEP(STEP), .MODE(MODE), .BTN_PRESS(BTN_PRESS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int press_cnt = 0;
  int step_cnt  = 0;
  int coincide  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: button history, run length of disagreement, mode and
  // cycles elapsed in the current run since the last mode change
  int m_hist[2];      // [0] newest sample, [1] synchronised level
  int m_deb, m_run, m_mode, m_elapsed, m_pos;
  bit m_step, m_press, m_np;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_hist[0] = 1; m_hist[1] = 1;
      m_deb = 1; m_run = 0; m_mode = 0; m_elapsed = 0; m_pos = 0;
      m_step = 0; m_press = 0;
    end else begin
      m_np = 0;
      if (m_hist[1] == m_deb) m_run = 0;
      else if (m_run == DEB_WIN) begin
        m_np = (m_deb == 1);
        m_deb = m_hist[1];
        m_run = 0;
      end else m_run++;

      m_step = 0;
      if (m_press) begin
        if (m_mode != 2 && (m_elapsed + 1) % PER == 0) coincide++;
        m_mode = (m_mode + 1) % 3;
        m_elapsed = 0;
      end else if (m_mode != 2) begin
        m_elapsed++;
        if (m_elapsed % PER == 0) begin
          m_step = 1;
          m_pos = (m_mode == 0) ? (m_pos + 1) % NPOS : (m_pos + NPOS - 1) % NPOS;
        end
      end
      m_press = m_np;
      m_hist[1] = m_hist[0];
      m_hist[0] = int'(BTN_N);
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    if (RST_N) begin
      check("pos",       int'(POS),       m_pos);
      check("step",      int'(STEP),      int'(m_step));
      check("mode",      int'(MODE),      m_mode);
      check("btn_press", int'(BTN_PRESS), int'(m_press));
      if (BTN_PRESS) press_cnt++;
      if (STEP) step_cnt++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic press();
    BTN_N = 1'b0;
    cycles(10);
    BTN_N = 1'b1;
    cycles(10);
  endtask

  int p0, s0, frozen, cnt;
  bit found;

  initial begin
    BTN_N = 1'b1;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #1;
    check("reset_pos",  int'(POS), 0);
    check("reset_step", int'(STEP), 0);
    check("reset_mode", int'(MODE), 0);
    check("reset_btn",  int'(BTN_PRESS), 0);
    cycles(3);
    RST_N = 1'b1;

    // Forward run: first step lands on position 1, then wrap 22 -> 0
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge CLK);
      if (STEP) found = 1;
    end
    check("first_step_seen", int'(found), 1);
    check("first_step_pos", int'(POS), 1);
    found = 0;
    for (int i = 0; i < 120 && !found; i++) begin
      @(negedge CLK);
      if (STEP && POS == 5'd22) found = 1;
    end
    check("reach_22", int'(found), 1);
    repeat (PER) @(negedge CLK);
    check("fwd_wrap_pos", int'(POS), 0);
    check("fwd_wrap_step", int'(STEP), 1);
    cycles(1);

    // Short glitches must not register as presses
    p0 = press_cnt;
    for (int i = 0; i < 5; i++) begin
      BTN_N = 1'b0; cycles(2);
      BTN_N = 1'b1; cycles(6);
    end
    check("bounce_presses", press_cnt - p0, 0);
    check("bounce_mode", int'(MODE), 0);

    // One real press -> reverse run, let it wrap through 0
    p0 = press_cnt;
    press();
    check("rev_presses", press_cnt - p0, 1);
    check("rev_mode", int'(MODE), 1);
    cycles(100);

    // Pause: position frozen, no steps
    press();
    check("pause_mode", int'(MODE), 2);
    frozen = int'(POS);
    s0 = step_cnt;
    cycles(100);
    check("pause_pos", int'(POS), frozen);
    check("pause_steps", step_cnt - s0, 0);

    // Resume: first step exactly one period after the mode change
    BTN_N = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge CLK);
      if (MODE == 2'b00) found = 1;
    end
    check("resume_mode", int'(found), 1);
    cnt = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge CLK);
      cnt++;
      if (STEP) found = 1;
    end
    check("resume_latency", cnt, PER);
    check("resume_pos", int'(POS), (frozen + 1) % NPOS);
    cycles(1);
    BTN_N = 1'b1;
    cycles(10);

    // Sweep press timing so a mode change meets a prescaler wrap
    for (int k = 0; k < 8; k++) begin
      cycles(k);
      press();
    end
    check("coincidence_seen", int'(coincide > 0), 1);

    // Randomised button activity
    for (int i = 0; i < 40; i++) begin
      BTN_N = 1'b0; cycles($urandom_range(1, 12));
      BTN_N = 1'b1; cycles($urandom_range(1, 30));
    end
    cycles(10);

    // Get into reverse run, then pulse reset between clock edges
    for (int i = 0; i < 3 && m_mode != 1; i++) press();
    check("pre_reset_mode", int'(MODE), 1);
    cycles(9);
    #1 RST_N = 1'b0;
    #1;
    check("async_pos",  int'(POS), 0);
    check("async_mode", int'(MODE), 0);
    check("async_step", int'(STEP), 0);
    check("async_btn",  int'(BTN_PRESS), 0);
    cycles(2);

    // Button held through reset gives exactly one press after release
    BTN_N = 1'b0;
    cycles(2);
    p0 = press_cnt;
    RST_N = 1'b1;
    cycles(20);
    check("held_presses", press_cnt - p0, 1);
    check("held_mode", int'(MODE), 1);
    BTN_N = 1'b1;
    cycles(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
